counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  Parametrised bank of N_CH up/down counters sharing one clock and one programmable prescaler.
//  Each channel has clear, load, up, down and auto-count controls, wrap or saturate mode, and a compare register.
//  Sits between host-endpoint wires/triggers and the user logic: controls come from WireIn/TriggerIn,
//  counts go to WireOut, and match/wrap flags drive TriggerOut.
// PARAMETERS
//  N_CH       4   number of counter channels (1..16)
//  WIDTH      16  counter width per channel (2..32)
//  DIV_WIDTH  24  prescaler width
// PORTS
//  clk          in   1             single clock; all logic is in this domain
//  reset_n      in   1             asynchronous, active-low reset
//  div_term     in   DIV_WIDTH     prescaler terminal value; tick period = div_term+1 clocks
//  auto_en      in   N_CH          level; count up on each prescaler tick
//  sat_mode     in   N_CH          level; 1 = saturate at 0/max, 0 = wrap
//  clr          in   N_CH          pulse; count <= 0
//  load         in   N_CH          pulse; count <= load_val slice
//  up           in   N_CH          pulse; +1
//  down         in   N_CH          pulse; -1
//  load_val     in   N_CH*WIDTH    channel i at [i*WIDTH +: WIDTH]
//  cmp_val      in   N_CH*WIDTH    compare values, same packing
//  count        out  N_CH*WIDTH    live counts, same packing
//  eq_zero      out  N_CH          registered (count==0)
//  eq_cmp       out  N_CH          registered (count==cmp_val)
//  wrap_pulse   out  N_CH          1-cycle pulse on wrap, either direction
//  tick         out  1             1-cycle prescaler tick
// BEHAVIOUR
//  - Reset (reset_n=0, async): count=0, div=div_term latched at first clock after release, tick=0, wrap_pulse=0,
//    eq_zero=all 1s one clock after release (0 during reset), eq_cmp=0. All outputs are registered.
//  - Prescaler: div counts down; at div==0 it reloads div_term and tick=1 for that single cycle.
//    div_term=0 gives tick every cycle. A div_term change takes effect at the next reload.
//  - Per-channel priority, evaluated every clock: clr > load > up > down > (auto_en & tick).
//    Only the highest-priority action applies; up&down together => up.
//  - Latency: the action at edge k is visible on count after edge k; eq_zero/eq_cmp follow one clock later.
//  - Wrap mode: max+1 -> 0 and 0-1 -> max, wrap_pulse=1 in the same cycle count shows the wrapped value.
//  - Saturate mode: count holds at max (up) or 0 (down); wrap_pulse stays 0.
//  - load/clr never raise wrap_pulse. sat_mode is sampled per operation, so mid-run changes are legal.
//  - eq_cmp is a level flag; the host side builds edge triggers.
// CONFIGURATION
//  - CTR_CAPTURE_EN defined: adds input capture (1) and output snap (N_CH*WIDTH).
//    A capture pulse copies all counts into snap on the same edge, giving a coherent multi-channel readout.
//    snap resets to 0 and holds until the next capture.
//  - CTR_CAPTURE_EN undefined: no capture or snap ports, no snapshot flops.
// STRUCTURE
//  - counter_bank_pkg: localparam codes for the action select (ACT_NONE, ACT_CLR, ACT_LOAD, ACT_UP, ACT_DN, ACT_AUTO)
//    and a function that resolves the priority into an action code.
//  - Sub-module counter_bank_ch: one channel (count, wrap/sat arithmetic, flags), instantiated N_CH times
//    with a generate loop. The prescaler and capture logic stay in the top level.
// TESTING
//  1. Reset release, div_term=3, auto_en=1: tick every 4th clock; count 0->1->2 on ticks;
//     eq_zero drops one clock after count=1.
//  2. WIDTH=8, wrap mode, load 8'hFE, two up pulses: count FE->FF->00, wrap_pulse exactly on the 00 cycle;
//     a down pulse then gives FF with wrap_pulse.
//  3. Saturate mode, count FF, up pulse: count stays FF, wrap_pulse=0. At count 00, down pulse: count stays 00.
//  4. Same-cycle clr+load+up on ch0 and up+down on ch1: ch0=0, ch1 increments; other channels unchanged.
//  5. cmp_val=5, up pulses from 0: eq_cmp rises one clock after count=5, falls one clock after count=6.
//  6. reset_n low mid-count with tick pending: all outputs clear immediately; counting resumes from 0.
//     With CTR_CAPTURE_EN: a capture while ch0 counts 7 makes snap ch0=7, and snap holds while count advances.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Action codes and priority resolution shared by the counter bank and its channels.
// Pure combinational helpers; no state.
package counter_bank_pkg;

    localparam logic [2:0] ACT_NONE = 3'd0;
    localparam logic [2:0] ACT_CLR  = 3'd1;
    localparam logic [2:0] ACT_LOAD = 3'd2;
    localparam logic [2:0] ACT_UP   = 3'd3;
    localparam logic [2:0] ACT_DN   = 3'd4;
    localparam logic [2:0] ACT_AUTO = 3'd5;

    // Exactly one action per channel per clock; up wins over down when both pulse.
    function automatic logic [2:0] resolve_act(
        input logic clr,
        input logic load,
        input logic up,
        input logic down,
        input logic auto_tick
    );
        if (clr)            return ACT_CLR;
        else if (load)      return ACT_LOAD;
        else if (up)        return ACT_UP;
        else if (down)      return ACT_DN;
        else if (auto_tick) return ACT_AUTO;
        else                return ACT_NONE;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One up/down counter channel with wrap/saturate arithmetic and registered zero/compare flags.
// Count updates 1 clk after the action; flags 1 clk after count. No backpressure: acts every clock.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic             up,
    input  logic             down,
    input  logic             auto_tick,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             eq_zero,
    output logic             eq_cmp,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [2:0]       act;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    always_comb begin
        act       = resolve_act(clr, load, up, down, auto_tick);
        count_nxt = count;
        wrap_nxt  = 1'b0;
        case (act)
            ACT_CLR:  count_nxt = '0;
            ACT_LOAD: count_nxt = load_val;
            ACT_UP, ACT_AUTO: begin
                if (count == MAX_VAL) begin
                    // saturate leaves count_nxt at MAX_VAL
                    if (!sat_mode) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            ACT_DN: begin
                if (count == '0) begin
                    if (!sat_mode) begin
                        count_nxt = MAX_VAL;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            eq_zero    <= 1'b0;
            eq_cmp     <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
            eq_zero    <= (count == '0);
            eq_cmp     <= (count == cmp_val);
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH up/down counters sharing a programmable prescaler; optional coherent snapshot (CTR_CAPTURE_EN).
// Counts update 1 clk after the control edge, flags 1 clk later. No backpressure: controls act every clock.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIV_WIDTH-1:0]  div_term,
    input  logic [N_CH-1:0]       auto_en,
    input  logic [N_CH-1:0]       sat_mode,
    input  logic [N_CH-1:0]       clr,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH-1:0]       up,
    input  logic [N_CH-1:0]       down,
    input  logic [N_CH*WIDTH-1:0] load_val,
    input  logic [N_CH*WIDTH-1:0] cmp_val,
`ifdef CTR_CAPTURE_EN
    input  logic                  capture,
    output logic [N_CH*WIDTH-1:0] snap,
`endif
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       eq_zero,
    output logic [N_CH-1:0]       eq_cmp,
    output logic [N_CH-1:0]       wrap_pulse,
    output logic                  tick
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("counter_bank: N_CH must be 1..16");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_bank: WIDTH must be 2..32");
    end

    logic [DIV_WIDTH-1:0] div;
    logic                 div_run;

    // First clock after reset only latches div_term, so the first tick comes div_term+1 clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            div_run <= 1'b0;
            tick    <= 1'b0;
        end else if (!div_run) begin
            div_run <= 1'b1;
            div     <= div_term;
            tick    <= 1'b0;
        end else if (div == '0) begin
            div     <= div_term;
            tick    <= 1'b1;
        end else begin
            div     <= div - 1'b1;
            tick    <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        counter_bank_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr        (clr[i]),
            .load       (load[i]),
            .up         (up[i]),
            .down       (down[i]),
            .auto_tick  (auto_en[i] & tick),
            .sat_mode   (sat_mode[i]),
            .load_val   (load_val[i*WIDTH +: WIDTH]),
            .cmp_val    (cmp_val[i*WIDTH +: WIDTH]),
            .count      (count[i*WIDTH +: WIDTH]),
            .eq_zero    (eq_zero[i]),
            .eq_cmp     (eq_cmp[i]),
            .wrap_pulse (wrap_pulse[i])
        );
    end

`ifdef CTR_CAPTURE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
        end else if (capture) begin
            snap <= count;
        end
    end
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: a cycle model pushes expected outputs per clock, popped after each edge.
// Directed scenarios add explicit constant checks on top of the per-cycle comparisons.
module tb_counter_bank;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [DW-1:0]   div_term;
    logic [N-1:0]    auto_en, sat_mode, clr, load, up, down;
    logic [N*W-1:0]  load_val, cmp_val;
    logic [N*W-1:0]  count;
    logic [N-1:0]    eq_zero, eq_cmp, wrap_pulse;
    logic            tick;
`ifdef CTR_CAPTURE_EN
    logic            capture;
    logic [N*W-1:0]  snap;
`endif

    always #5 clk = ~clk;

    counter_bank #(.N_CH(N), .WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .div_term   (div_term),
        .auto_en    (auto_en),
        .sat_mode   (sat_mode),
        .clr        (clr),
        .load       (load),
        .up         (up),
        .down       (down),
        .load_val   (load_val),
        .cmp_val    (cmp_val),
`ifdef CTR_CAPTURE_EN
        .capture    (capture),
        .snap       (snap),
`endif
        .count      (count),
        .eq_zero    (eq_zero),
        .eq_cmp     (eq_cmp),
        .wrap_pulse (wrap_pulse),
        .tick       (tick)
    );

    typedef struct packed {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   wr;
        logic [N-1:0]   ez;
        logic [N-1:0]   ec;
        logic           tk;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    logic [W-1:0] mcnt [N];
    logic [N-1:0] mwrap, mez, mec;
    logic         mtick, mst;
    logic [DW-1:0] mdiv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = '0;
        mwrap = '0; mez = '0; mec = '0;
        mtick = 1'b0; mst = 1'b0; mdiv = '0;
    endtask

    // Advance one clock: predict, push, wait for the edge, pop and compare.
    task automatic step();
        exp_t         e, got;
        int           v, d;
        int           maxv;
        logic [W-1:0] nc [N];
        logic         ntick;
        maxv = (1 << W) - 1;
        for (int i = 0; i < N; i++) begin
            v = int'(mcnt[i]);
            d = 0;
            mwrap[i] = 1'b0;
            mez[i] = (mcnt[i] == '0);
            mec[i] = (mcnt[i] == cmp_val[i*W +: W]);
            if (clr[i])                   v = 0;
            else if (load[i])             v = int'(load_val[i*W +: W]);
            else if (up[i])               d = 1;
            else if (down[i])             d = -1;
            else if (auto_en[i] && mtick) d = 1;
            v = v + d;
            if (v > maxv) begin
                v = sat_mode[i] ? maxv : 0;
                mwrap[i] = !sat_mode[i];
            end else if (v < 0) begin
                v = sat_mode[i] ? 0 : maxv;
                mwrap[i] = !sat_mode[i];
            end
            nc[i] = W'(v);
        end
        if (!mst) begin
            mst = 1'b1; mdiv = div_term; ntick = 1'b0;
        end else if (mdiv == 0) begin
            mdiv = div_term; ntick = 1'b1;
        end else begin
            mdiv = mdiv - 1; ntick = 1'b0;
        end
        mtick = ntick;
        for (int i = 0; i < N; i++) begin
            mcnt[i] = nc[i];
            e.cnt[i*W +: W] = nc[i];
        end
        e.wr = mwrap; e.ez = mez; e.ec = mec; e.tk = mtick;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_count",   64'(count),      64'(got.cnt));
        check("sb_wrap",    64'(wrap_pulse), 64'(got.wr));
        check("sb_eq_zero", 64'(eq_zero),    64'(got.ez));
        check("sb_eq_cmp",  64'(eq_cmp),     64'(got.ec));
        check("sb_tick",    64'(tick),       64'(got.tk));
        clr = '0; load = '0; up = '0; down = '0;
`ifdef CTR_CAPTURE_EN
        capture = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, cz, c5, rise, fall;
        reset_n = 1'b0;
        div_term = 24'd3;
        auto_en = 4'b0001; sat_mode = '0;
        clr = '0; load = '0; up = '0; down = '0;
        load_val = '0; cmp_val = '0;
`ifdef CTR_CAPTURE_EN
        capture = 1'b0;
`endif
        model_reset();
        #12;
        check("rst_count",   64'(count),      64'd0);
        check("rst_eq_zero", 64'(eq_zero),    64'd0);
        check("rst_tick",    64'(tick),       64'd0);
        check("rst_wrap",    64'(wrap_pulse), 64'd0);
        reset_n = 1'b1;

        // Prescaler and auto-count after release
        c1 = -1; cz = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (c1 < 0 && count[W-1:0] == 8'd1) c1 = k;
            if (cz < 0 && k > 1 && !eq_zero[0]) cz = k;
        end
        check("t1_first_inc", 64'(c1), 64'd6);
        check("t1_ez_lag",    64'(cz - c1), 64'd1);
        check("t1_count",     64'(count[W-1:0]), 64'd2);
        auto_en = '0;

        // Wrap mode around the top
        load_val[W-1:0] = 8'hFE; load[0] = 1'b1; step();
        check("t2_load", 64'(count[W-1:0]), 64'hFE);
        up[0] = 1'b1; step();
        check("t2_ff",      64'(count[W-1:0]), 64'hFF);
        check("t2_ff_wrap", 64'(wrap_pulse[0]), 64'd0);
        up[0] = 1'b1; step();
        check("t2_00",      64'(count[W-1:0]), 64'h00);
        check("t2_00_wrap", 64'(wrap_pulse[0]), 64'd1);
        down[0] = 1'b1; step();
        check("t2_dn_ff",   64'(count[W-1:0]), 64'hFF);
        check("t2_dn_wrap", 64'(wrap_pulse[0]), 64'd1);

        // Saturate mode at both ends
        sat_mode[0] = 1'b1;
        up[0] = 1'b1; step();
        check("t3_sat_hi",      64'(count[W-1:0]), 64'hFF);
        check("t3_sat_hi_wrap", 64'(wrap_pulse[0]), 64'd0);
        clr[0] = 1'b1; step();
        down[0] = 1'b1; step();
        check("t3_sat_lo",      64'(count[W-1:0]), 64'h00);
        check("t3_sat_lo_wrap", 64'(wrap_pulse[0]), 64'd0);
        sat_mode[0] = 1'b0;

        // Priority resolution
        load_val = {8'h44, 8'h33, 8'h10, 8'h00}; load = 4'b1110; step();
        load_val[W-1:0] = 8'h55;
        clr[0] = 1'b1; load[0] = 1'b1; up[0] = 1'b1;
        up[1] = 1'b1; down[1] = 1'b1;
        step();
        check("t4_prio", 64'(count), 64'h4433_1100);

        // Compare flag timing
        cmp_val[W-1:0] = 8'd5;
        clr[0] = 1'b1; step();
        c5 = -1; rise = -1; fall = -1;
        for (int k = 1; k <= 7; k++) begin
            up[0] = 1'b1; step();
            if (c5 < 0 && count[W-1:0] == 8'd5) c5 = k;
            if (rise < 0 && eq_cmp[0]) rise = k;
            else if (rise > 0 && fall < 0 && !eq_cmp[0]) fall = k;
        end
        check("t5_rise_lag", 64'(rise - c5), 64'd1);
        check("t5_fall_lag", 64'(fall - (c5 + 1)), 64'd1);

        // Async reset mid-count, then resume from zero
        div_term = 24'd3; auto_en = '1;
        for (int k = 0; k < 6; k++) step();
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_count", 64'(count),      64'd0);
        check("t6_rst_tick",  64'(tick),       64'd0);
        check("t6_rst_ez",    64'(eq_zero),    64'd0);
        check("t6_rst_ec",    64'(eq_cmp),     64'd0);
        check("t6_rst_wrap",  64'(wrap_pulse), 64'd0);
        model_reset();
        #10 reset_n = 1'b1;
        for (int k = 0; k < 12; k++) step();
        check("t6_resume", 64'(count), 64'h0202_0202);

        // Randomised mix, checked only by the scoreboard
        for (int k = 0; k < 300; k++) begin
            if (k % 50 == 0) div_term = DW'($urandom_range(0, 2));
            sat_mode = N'($urandom);
            auto_en  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                clr[i]  = ($urandom_range(0, 15) == 0);
                load[i] = ($urandom_range(0, 9) == 0);
                up[i]   = ($urandom_range(0, 2) == 0);
                down[i] = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 4))
                    0:       load_val[i*W +: W] = 8'h00;
                    1:       load_val[i*W +: W] = 8'hFF;
                    2:       load_val[i*W +: W] = 8'hFE;
                    3:       load_val[i*W +: W] = 8'h01;
                    default: load_val[i*W +: W] = W'($urandom);
                endcase
                if ($urandom_range(0, 7) == 0) cmp_val[i*W +: W] = W'($urandom_range(0, 3));
            end
            step();
        end

`ifdef CTR_CAPTURE_EN
        auto_en = '0;
        load_val[W-1:0] = 8'd7; load[0] = 1'b1; step();
        capture = 1'b1; step();
        check("cap_snap", 64'(snap[W-1:0]), 64'd7);
        up[0] = 1'b1; step();
        up[0] = 1'b1; step();
        check("cap_count", 64'(count[W-1:0]), 64'd9);
        check("cap_hold",  64'(snap[W-1:0]),  64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
